ip_tx_sched: RTL and testbench

//  Round-robin scheduler sharing one ip_eth_tx instance between PORTS independent IP frame sources.

---
 rtl/ip_pkg.sv | 72 +++++++
 rtl/rr_pick.sv | 37 +++
 rtl/ip_tx_sched.sv | 148 ++++++++++++++
 tb/tb_ip_tx_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
// Shared definitions for the IP transmit path: packed header layout and the
// scheduler state encoding.
package ip_pkg;

    // Packed header width; the whole transmit path depends on this layout.
    localparam int unsigned HDR_W = 248;

    // Field widths, MSB-first order of the packed header.
    localparam int unsigned DEST_MAC_W  = 48;
    localparam int unsigned SRC_MAC_W   = 48;
    localparam int unsigned ETH_TYPE_W  = 16;
    localparam int unsigned DSCP_W      = 6;
    localparam int unsigned ECN_W       = 2;
    localparam int unsigned LENGTH_W    = 16;
    localparam int unsigned ID_W        = 16;
    localparam int unsigned FLAGS_W     = 3;
    localparam int unsigned FRAG_OFF_W  = 13;
    localparam int unsigned TTL_W       = 8;
    localparam int unsigned PROTOCOL_W  = 8;
    localparam int unsigned SRC_IP_W    = 32;
    localparam int unsigned DEST_IP_W   = 32;

    // Field LSB offsets within the packed header.
    localparam int unsigned DEST_IP_OFF  = 0;
    localparam int unsigned SRC_IP_OFF   = DEST_IP_OFF + DEST_IP_W;
    localparam int unsigned PROTOCOL_OFF = SRC_IP_OFF + SRC_IP_W;
    localparam int unsigned TTL_OFF      = PROTOCOL_OFF + PROTOCOL_W;
    localparam int unsigned FRAG_OFF_OFF = TTL_OFF + TTL_W;
    localparam int unsigned FLAGS_OFF    = FRAG_OFF_OFF + FRAG_OFF_W;
    localparam int unsigned ID_OFF       = FLAGS_OFF + FLAGS_W;
    localparam int unsigned LENGTH_OFF   = ID_OFF + ID_W;
    localparam int unsigned ECN_OFF      = LENGTH_OFF + LENGTH_W;
    localparam int unsigned DSCP_OFF     = ECN_OFF + ECN_W;
    localparam int unsigned ETH_TYPE_OFF = DSCP_OFF + DSCP_W;
    localparam int unsigned SRC_MAC_OFF  = ETH_TYPE_OFF + ETH_TYPE_W;
    localparam int unsigned DEST_MAC_OFF = SRC_MAC_OFF + SRC_MAC_W;

    // Structured view of the packed header; bit-identical to the flat vector.
    typedef struct packed {
        logic [DEST_MAC_W-1:0] dest_mac;
        logic [SRC_MAC_W-1:0]  src_mac;
        logic [ETH_TYPE_W-1:0] eth_type;
        logic [DSCP_W-1:0]     dscp;
        logic [ECN_W-1:0]      ecn;
        logic [LENGTH_W-1:0]   length;
        logic [ID_W-1:0]       id;
        logic [FLAGS_W-1:0]    flags;
        logic [FRAG_OFF_W-1:0] frag_off;
        logic [TTL_W-1:0]      ttl;
        logic [PROTOCOL_W-1:0] protocol;
        logic [SRC_IP_W-1:0]   src_ip;
        logic [DEST_IP_W-1:0]  dest_ip;
    } ip_hdr_t;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
    } sched_state_e;

    // Increment modulo n without relying on n being a power of two.
    function automatic int unsigned rr_wrap_inc(input int unsigned cur, input int unsigned n);
        int unsigned nxt;
        nxt = cur + 1;
        if (nxt >= n) begin
            nxt = 0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: finds the first set request at or after the pointer,
// wrapping modulo PORTS.
module rr_pick
    import ip_pkg::*;
#(
    parameter int unsigned PORTS = 4,
    parameter int unsigned IDX_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            cand = 32'(ptr) + 32'(i);
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            cand_idx = cand[IDX_W-1:0];
            if (req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/ip_tx_sched.sv
// Round-robin scheduler that shares one IP frame transmitter between PORTS
// sources. A grant is taken in IDLE and held from header accept to payload
// tlast; header and payload of the granted source are muxed combinationally.
module ip_tx_sched
    import ip_pkg::*;
#(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    // Tied to the package layout; overriding it breaks the header format.
    parameter int unsigned HDR_W      = ip_pkg::HDR_W
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [PORTS-1:0]            s_ip_hdr_valid,
    output logic [PORTS-1:0]            s_ip_hdr_ready,
    input  logic [PORTS*HDR_W-1:0]      s_ip_hdr_data,
    input  logic [PORTS*DATA_WIDTH-1:0] s_ip_payload_axis_tdata,
    input  logic [PORTS-1:0]            s_ip_payload_axis_tvalid,
    output logic [PORTS-1:0]            s_ip_payload_axis_tready,
    input  logic [PORTS-1:0]            s_ip_payload_axis_tlast,
    input  logic [PORTS-1:0]            s_ip_payload_axis_tuser,

    output logic                        m_ip_hdr_valid,
    input  logic                        m_ip_hdr_ready,
    output logic [HDR_W-1:0]            m_ip_hdr_data,
    output logic [DATA_WIDTH-1:0]       m_ip_payload_axis_tdata,
    output logic                        m_ip_payload_axis_tvalid,
    input  logic                        m_ip_payload_axis_tready,
    output logic                        m_ip_payload_axis_tlast,
    output logic                        m_ip_payload_axis_tuser,

    output logic [$clog2(PORTS)-1:0]    grant_index,
    output logic                        busy
);

    localparam int unsigned IDX_W = $clog2(PORTS);

    sched_state_e     state_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] ptr_q;
    logic             busy_q;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    // Granted-source view of the inputs.
    logic [PORTS-1:0]      gnt_onehot;
    logic                  sel_hdr_valid;
    logic [HDR_W-1:0]      sel_hdr_data;
    logic [DATA_WIDTH-1:0] sel_tdata;
    logic                  sel_tvalid;
    logic                  sel_tlast;
    logic                  sel_tuser;

    logic                  hdr_fire;
    logic                  last_fire;

    rr_pick #(
        .PORTS (PORTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (s_ip_hdr_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Select the granted source's signals; grant_q never exceeds PORTS-1.
    always_comb begin
        gnt_onehot    = '0;
        sel_hdr_valid = 1'b0;
        sel_hdr_data  = '0;
        sel_tdata     = '0;
        sel_tvalid    = 1'b0;
        sel_tlast     = 1'b0;
        sel_tuser     = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                gnt_onehot[i] = 1'b1;
                sel_hdr_valid = s_ip_hdr_valid[i];
                sel_hdr_data  = s_ip_hdr_data[i*HDR_W +: HDR_W];
                sel_tdata     = s_ip_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_tvalid    = s_ip_payload_axis_tvalid[i];
                sel_tlast     = s_ip_payload_axis_tlast[i];
                sel_tuser     = s_ip_payload_axis_tuser[i];
            end
        end
    end

    // Drive the shared output and route ready back to the granted source only.
    always_comb begin
        m_ip_hdr_valid           = (state_q == HDR) && sel_hdr_valid;
        m_ip_hdr_data            = sel_hdr_data;
        s_ip_hdr_ready           = (state_q == HDR && m_ip_hdr_ready) ? gnt_onehot : '0;

        m_ip_payload_axis_tvalid = (state_q == PAYLOAD) && sel_tvalid;
        m_ip_payload_axis_tdata  = sel_tdata;
        m_ip_payload_axis_tlast  = sel_tlast;
        m_ip_payload_axis_tuser  = sel_tuser;
        s_ip_payload_axis_tready = (state_q == PAYLOAD && m_ip_payload_axis_tready) ?
                                   gnt_onehot : '0;

        hdr_fire  = m_ip_hdr_valid && m_ip_hdr_ready;
        last_fire = m_ip_payload_axis_tvalid && m_ip_payload_axis_tready && sel_tlast;
    end

    // Grant FSM: pick in IDLE, hold through header and payload, release on tlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        state_q <= HDR;
                        busy_q  <= 1'b1;
                    end
                end
                HDR: begin
                    // A source dropping hdr_valid here simply stalls the grant.
                    if (hdr_fire) begin
                        state_q <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (last_fire) begin
                        ptr_q   <= IDX_W'(rr_wrap_inc(32'(grant_q), PORTS));
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_index = grant_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ip_tx_sched.sv
// Directed bench for ip_tx_sched: a table of frames with hand-computed grant
// order, plus hand-written sequences for reset and header stall.
module tb_ip_tx_sched;
    import ip_pkg::*;

    localparam int P  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [P-1:0]       s_hdr_valid;
    logic [P-1:0]       s_hdr_ready;
    logic [P*HDR_W-1:0] s_hdr_data;
    logic [P*DW-1:0]    s_tdata;
    logic [P-1:0]       s_tvalid;
    logic [P-1:0]       s_tready;
    logic [P-1:0]       s_tlast;
    logic [P-1:0]       s_tuser;
    logic               m_hdr_valid, m_hdr_ready;
    logic [HDR_W-1:0]   m_hdr_data;
    logic [DW-1:0]      m_tdata;
    logic               m_tvalid, m_tready, m_tlast, m_tuser;
    logic [1:0]         grant;
    logic               busy;

    // Three-port instance shares the low three sources.
    logic [2:0]         s3_hdr_ready, s3_tready;
    logic               m3_hdr_valid;
    logic [HDR_W-1:0]   m3_hdr_data;
    logic [DW-1:0]      m3_tdata;
    logic               m3_tvalid, m3_tlast, m3_tuser;
    logic [1:0]         grant3;
    logic               busy3;

    ip_tx_sched #(.PORTS(P), .DATA_WIDTH(DW)) u_dut (
        .clk                      (clk),
        .rst                      (rst),
        .s_ip_hdr_valid           (s_hdr_valid),
        .s_ip_hdr_ready           (s_hdr_ready),
        .s_ip_hdr_data            (s_hdr_data),
        .s_ip_payload_axis_tdata  (s_tdata),
        .s_ip_payload_axis_tvalid (s_tvalid),
        .s_ip_payload_axis_tready (s_tready),
        .s_ip_payload_axis_tlast  (s_tlast),
        .s_ip_payload_axis_tuser  (s_tuser),
        .m_ip_hdr_valid           (m_hdr_valid),
        .m_ip_hdr_ready           (m_hdr_ready),
        .m_ip_hdr_data            (m_hdr_data),
        .m_ip_payload_axis_tdata  (m_tdata),
        .m_ip_payload_axis_tvalid (m_tvalid),
        .m_ip_payload_axis_tready (m_tready),
        .m_ip_payload_axis_tlast  (m_tlast),
        .m_ip_payload_axis_tuser  (m_tuser),
        .grant_index              (grant),
        .busy                     (busy)
    );

    ip_tx_sched #(.PORTS(3), .DATA_WIDTH(DW)) u_dut3 (
        .clk                      (clk),
        .rst                      (rst),
        .s_ip_hdr_valid           (s_hdr_valid[2:0]),
        .s_ip_hdr_ready           (s3_hdr_ready),
        .s_ip_hdr_data            (s_hdr_data[3*HDR_W-1:0]),
        .s_ip_payload_axis_tdata  (s_tdata[3*DW-1:0]),
        .s_ip_payload_axis_tvalid (s_tvalid[2:0]),
        .s_ip_payload_axis_tready (s3_tready),
        .s_ip_payload_axis_tlast  (s_tlast[2:0]),
        .s_ip_payload_axis_tuser  (s_tuser[2:0]),
        .m_ip_hdr_valid           (m3_hdr_valid),
        .m_ip_hdr_ready           (m_hdr_ready),
        .m_ip_hdr_data            (m3_hdr_data),
        .m_ip_payload_axis_tdata  (m3_tdata),
        .m_ip_payload_axis_tvalid (m3_tvalid),
        .m_ip_payload_axis_tready (m_tready),
        .m_ip_payload_axis_tlast  (m3_tlast),
        .m_ip_payload_axis_tuser  (m3_tuser),
        .grant_index              (grant3),
        .busy                     (busy3)
    );

    typedef struct {
        bit         use3;
        logic [3:0] mask;   // sources requesting at frame start
        logic [3:0] extra;  // sources raising hdr_valid during payload
        int         g;      // expected grant
        int         n;      // payload bytes
        logic [7:0] base;   // first payload byte
        bit         toggle; // throttle header/payload ready
        bit         tu;     // tuser on last byte
        int         abort;  // pulse reset after this many bytes (0 = none)
    } vec_t;

    typedef struct {
        logic             hdr_valid;
        logic [3:0]       hdr_ready;
        logic [HDR_W-1:0] hdr_data;
        logic             tvalid;
        logic [3:0]       tready;
        logic [7:0]       tdata;
        logic             tlast;
        logic             tuser;
        logic [1:0]       grant;
        logic             busy;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl [27];

    function automatic logic [HDR_W-1:0] mk_hdr(input int i);
        logic [7:0] b;
        b = 8'hA0 + 8'(i);
        return {31{b}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input bit use3, output obs_t o);
        if (use3) begin
            o.hdr_valid = m3_hdr_valid;
            o.hdr_ready = {1'b0, s3_hdr_ready};
            o.hdr_data  = m3_hdr_data;
            o.tvalid    = m3_tvalid;
            o.tready    = {1'b0, s3_tready};
            o.tdata     = m3_tdata;
            o.tlast     = m3_tlast;
            o.tuser     = m3_tuser;
            o.grant     = grant3;
            o.busy      = busy3;
        end else begin
            o.hdr_valid = m_hdr_valid;
            o.hdr_ready = s_hdr_ready;
            o.hdr_data  = m_hdr_data;
            o.tvalid    = m_tvalid;
            o.tready    = s_tready;
            o.tdata     = m_tdata;
            o.tlast     = m_tlast;
            o.tuser     = m_tuser;
            o.grant     = grant;
            o.busy      = busy;
        end
    endtask

    // Sources: the expected winner presents its byte stream, the others hold junk.
    task automatic drive(input logic [3:0] hv, input logic [3:0] tv, input vec_t v, input int k);
        s_hdr_valid = hv;
        s_tvalid    = tv;
        for (int i = 0; i < P; i++) begin
            if (i == v.g) begin
                s_tdata[i*DW +: DW] = v.base + 8'(k);
                s_tlast[i]          = (k == v.n - 1);
                s_tuser[i]          = v.tu && (k == v.n - 1);
            end else begin
                s_tdata[i*DW +: DW] = 8'hE0 | 8'(i);
                s_tlast[i]          = 1'b1;
                s_tuser[i]          = 1'b1;
            end
        end
    endtask

    task automatic run_row(input int row, input vec_t v);
        obs_t o;
        logic [3:0] hv, tv, gbit;
        int k, hcyc;
        bit done;
        string t;
        t    = $sformatf("r%0d", row);
        gbit = 4'b0001 << v.g;
        hv   = v.mask;
        tv   = v.mask;
        k    = 0;
        done = 1'b0;
        m_hdr_ready = 1'b1;
        m_tready    = 1'b1;
        drive(hv, tv, v, 0);
        #1 sample(v.use3, o);
        chk({t, " idle busy"},      o.busy,      0);
        chk({t, " idle hdr_ready"}, o.hdr_ready, 0);
        chk({t, " idle hdr_valid"}, o.hdr_valid, 0);
        chk({t, " idle tvalid"},    o.tvalid,    0);
        chk({t, " idle tready"},    o.tready,    0);
        @(posedge clk); #1;
        hcyc = v.toggle ? 2 : 1;
        for (int h = 0; h < hcyc; h++) begin
            m_hdr_ready = (h == hcyc - 1);
            #1 sample(v.use3, o);
            chk({t, " grant"},         o.grant,     v.g);
            chk({t, " hdr busy"},      o.busy,      1);
            chk({t, " hdr_valid"},     o.hdr_valid, 1);
            chk({t, " hdr_data"},      o.hdr_data,  mk_hdr(v.g));
            chk({t, " hdr_ready"},     o.hdr_ready, m_hdr_ready ? gbit : 4'b0000);
            chk({t, " hdr tvalid"},    o.tvalid,    0);
            @(posedge clk); #1;
        end
        hv = (hv & ~gbit) | v.extra;
        for (int c = 0; c < 64 && !done; c++) begin
            if (v.abort != 0 && k == v.abort) begin
                rst = 1'b1;
                hv  = '0;
                drive(hv, tv, v, k);
                @(posedge clk); #1;
                rst = 1'b0;
                #1 sample(v.use3, o);
                chk({t, " abort busy"},      o.busy,      0);
                chk({t, " abort grant"},     o.grant,     0);
                chk({t, " abort hdr_valid"}, o.hdr_valid, 0);
                chk({t, " abort tvalid"},    o.tvalid,    0);
                chk({t, " abort hdr_ready"}, o.hdr_ready, 0);
                chk({t, " abort tready"},    o.tready,    0);
                done = 1'b1;
            end else begin
                m_tready = v.toggle ? (c % 2 == 0) : 1'b1;
                drive(hv, tv, v, k);
                #1 sample(v.use3, o);
                chk({t, " pay busy"},      o.busy,      1);
                chk({t, " pay grant"},     o.grant,     v.g);
                chk({t, " pay tvalid"},    o.tvalid,    1);
                chk({t, " pay hdr_ready"}, o.hdr_ready, 0);
                chk({t, " pay tready"},    o.tready,    m_tready ? gbit : 4'b0000);
                if (m_tready) begin
                    chk($sformatf("%s tdata[%0d]", t, k), o.tdata, v.base + 8'(k));
                    chk($sformatf("%s tlast[%0d]", t, k), o.tlast, (k == v.n - 1));
                    chk($sformatf("%s tuser[%0d]", t, k), o.tuser, v.tu && (k == v.n - 1));
                end
                if (o.tready[v.g]) begin
                    if (k == v.n - 1) done = 1'b1;
                    k++;
                end
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: got %0d bytes required %0d", t, k, v.n);
        end
        tv = tv & ~gbit;
        m_tready = 1'b1;
        drive(hv, tv, v, k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        //             use3 mask     extra    g  n   base   tgl tu abort
        tbl[0]  = '{0, 4'b0010, 4'b0000, 1, 4,  8'h01, 0, 0, 0};
        tbl[1]  = '{0, 4'b0001, 4'b0000, 0, 8,  8'h30, 0, 0, 3};
        tbl[2]  = '{0, 4'b1000, 4'b0000, 3, 5,  8'h50, 0, 0, 0};
        tbl[3]  = '{0, 4'b1111, 4'b0000, 0, 2,  8'h60, 0, 0, 0};
        tbl[4]  = '{0, 4'b1111, 4'b0000, 1, 2,  8'h62, 0, 0, 0};
        tbl[5]  = '{0, 4'b1111, 4'b0000, 2, 2,  8'h64, 0, 0, 0};
        tbl[6]  = '{0, 4'b1111, 4'b0000, 3, 2,  8'h66, 0, 0, 0};
        tbl[7]  = '{0, 4'b1111, 4'b0000, 0, 2,  8'h68, 0, 0, 0};
        tbl[8]  = '{0, 4'b1111, 4'b0000, 1, 2,  8'h6A, 0, 0, 0};
        tbl[9]  = '{0, 4'b1111, 4'b0000, 2, 2,  8'h6C, 0, 0, 0};
        tbl[10] = '{0, 4'b1111, 4'b0000, 3, 2,  8'h6E, 0, 0, 0};
        tbl[11] = '{0, 4'b0100, 4'b0001, 2, 3,  8'h70, 0, 0, 0};
        tbl[12] = '{0, 4'b0001, 4'b0000, 0, 2,  8'h78, 0, 0, 0};
        tbl[13] = '{0, 4'b0010, 4'b0000, 1, 10, 8'h80, 1, 0, 0};
        tbl[14] = '{0, 4'b1001, 4'b0000, 3, 1,  8'h90, 0, 0, 0};
        tbl[15] = '{0, 4'b1001, 4'b0000, 0, 1,  8'h91, 0, 0, 0};
        tbl[16] = '{0, 4'b0001, 4'b0000, 0, 1,  8'h92, 0, 0, 0};
        tbl[17] = '{0, 4'b0001, 4'b0000, 0, 2,  8'h93, 0, 1, 0};
        tbl[18] = '{0, 4'b0110, 4'b0000, 1, 1,  8'h95, 0, 0, 0};
        tbl[19] = '{0, 4'b1100, 4'b0000, 2, 1,  8'h96, 0, 0, 0};
        tbl[20] = '{0, 4'b0011, 4'b0000, 0, 1,  8'h97, 0, 0, 0};
        tbl[21] = '{1, 4'b0010, 4'b0000, 1, 3,  8'hB0, 0, 1, 0};
        tbl[22] = '{1, 4'b0111, 4'b0000, 2, 2,  8'hB4, 0, 0, 0};
        tbl[23] = '{1, 4'b0111, 4'b0000, 0, 2,  8'hB8, 0, 0, 0};
        tbl[24] = '{1, 4'b0101, 4'b0000, 2, 1,  8'hBC, 0, 0, 0};
        tbl[25] = '{1, 4'b0110, 4'b0000, 1, 1,  8'hBD, 0, 1, 0};
        tbl[26] = '{1, 4'b0001, 4'b0000, 0, 2,  8'hBE, 0, 0, 0};

        rst         = 1'b1;
        s_hdr_valid = '0;
        s_tvalid    = '0;
        s_tdata     = '0;
        s_tlast     = '0;
        s_tuser     = '0;
        m_hdr_ready = 1'b0;
        m_tready    = 1'b0;
        for (int i = 0; i < P; i++) s_hdr_data[i*HDR_W +: HDR_W] = mk_hdr(i);

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 sample(0, o);
        chk("reset busy",      o.busy,      0);
        chk("reset grant",     o.grant,     0);
        chk("reset hdr_valid", o.hdr_valid, 0);
        chk("reset tvalid",    o.tvalid,    0);
        chk("reset hdr_ready", o.hdr_ready, 0);
        chk("reset tready",    o.tready,    0);

        for (int r = 0; r <= 20; r++) run_row(r, tbl[r]);

        // Source drops hdr_valid while granted: grant holds, nothing moves.
        s_hdr_valid = 4'b0100;
        s_tvalid    = '0;
        m_hdr_ready = 1'b1;
        @(posedge clk); #1;
        #1 sample(0, o);
        chk("stall grant",     o.grant,     2);
        chk("stall hdr_valid", o.hdr_valid, 1);
        s_hdr_valid = '0;
        for (int s = 0; s < 3; s++) begin
            #1 sample(0, o);
            chk($sformatf("stall%0d busy", s),      o.busy,      1);
            chk($sformatf("stall%0d grant", s),     o.grant,     2);
            chk($sformatf("stall%0d hdr_valid", s), o.hdr_valid, 0);
            chk($sformatf("stall%0d tvalid", s),    o.tvalid,    0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1 sample(0, o);
        chk("stall reset busy",  o.busy,  0);
        chk("stall reset grant", o.grant, 0);

        for (int r = 21; r <= 26; r++) run_row(r, tbl[r]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
